// File: rtl/fa_bist_pkg.sv
// ============================================================================
// Module  : fa_bist_pkg
// Brief   : Shared types, constants and golden model for the full-adder BIST.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fa_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 8;

    // Vector index packs {A,B,CI}; result packs {exp_CO, exp_S}.
    function automatic logic [1:0] fa_golden(input logic [2:0] v);
        logic a;
        logic b;
        logic ci;
        a  = v[2];
        b  = v[1];
        ci = v[0];
        return {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
    endfunction

endpackage : fa_bist_pkg

`default_nettype wire

// File: rtl/fa_cell_bist.sv
// ============================================================================
// Module  : fa_cell_bist
// Brief   : Closed-loop BIST sequencer that exercises one full-adder cell.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fa_cell_bist
    import fa_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       CK,
    input  logic       RN,
    input  logic       START,
    output logic       A,
    output logic       B,
    output logic       CI,
    input  logic       CO_IN,
    input  logic       S_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] FAIL_MASK,
    output logic [3:0] FAIL_CNT
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] LAST_VEC    = 3'(NUM_VECTORS - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] abc_q, abc_d;
    logic [7:0] mask_q, mask_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mismatch;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_IDLE;
            vec_q    <= 3'd0;
            settle_q <= 4'd0;
            abc_q    <= 3'd0;
            mask_q   <= 8'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            abc_q    <= abc_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        mask_d   = mask_q;
        cnt_d    = cnt_q;
        mismatch = ({CO_IN, S_IN} != fa_golden(vec_q));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d  = ST_DRIVE;
                    vec_d    = 3'd0;
                    settle_d = 4'd0;
                    mask_d   = 8'd0;
                    cnt_d    = 4'd0;
                end
            end
            ST_DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_CHECK;
                    settle_d = 4'd0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    mask_d[vec_q] = 1'b1;
                    cnt_d         = cnt_q + 4'd1;
                end
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Cell inputs follow the next vector so they are registered one edge ahead of use.
        abc_d = (state_d == ST_DRIVE || state_d == ST_CHECK) ? vec_d : 3'd0;
    end

    assign A         = abc_q[2];
    assign B         = abc_q[1];
    assign CI        = abc_q[0];
    assign BUSY      = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    assign DONE      = (state_q == ST_DONE);
    assign PASS      = (state_q == ST_DONE) && (cnt_q == 4'd0);
    assign FAIL_MASK = mask_q;
    assign FAIL_CNT  = cnt_q;

endmodule : fa_cell_bist

`default_nettype wire

// File: tb/tb_fa_cell_bist.sv
// ============================================================================
// Module  : tb_fa_cell_bist
// Brief   : Scoreboard bench for fa_cell_bist with default and 1-cycle settle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fa_cell_bist;

    logic       ck = 1'b0;
    logic       rn;
    logic       start0, start1;
    logic       a0, b0, ci0, co0, s0, busy0, done0, pass0;
    logic [7:0] mask0;
    logic [3:0] cnt0;
    logic       a1, b1, ci1, co1, s1, busy1, done1, pass1;
    logic [7:0] mask1;
    logic [3:0] cnt1;
    logic [1:0] sum0, sum1;
    int         mode;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] abc_sb[$];
    logic [7:0] mask_sb[$];

    always #5 ck = ~ck;

    // Behavioural cell models: 0 ideal, 1 S stuck-at-0, 2 CO inverted.
    assign sum0 = {1'b0, a0} + {1'b0, b0} + {1'b0, ci0};
    assign co0  = (mode == 2) ? ~sum0[1] : sum0[1];
    assign s0   = (mode == 1) ? 1'b0 : sum0[0];
    assign sum1 = {1'b0, a1} + {1'b0, b1} + {1'b0, ci1};
    assign co1  = sum1[1];
    assign s1   = sum1[0];

    fa_cell_bist #(.SETTLE_CYCLES(2)) u_dut0 (
        .CK(ck), .RN(rn), .START(start0), .A(a0), .B(b0), .CI(ci0),
        .CO_IN(co0), .S_IN(s0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
        .FAIL_MASK(mask0), .FAIL_CNT(cnt0)
    );

    fa_cell_bist #(.SETTLE_CYCLES(1)) u_dut1 (
        .CK(ck), .RN(rn), .START(start1), .A(a1), .B(b1), .CI(ci1),
        .CO_IN(co1), .S_IN(s1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .FAIL_MASK(mask1), .FAIL_CNT(cnt1)
    );

    task automatic push_expected(input int hold, input logic [7:0] emask);
        for (int v = 0; v < 8; v++)
            for (int k = 0; k < hold; k++)
                abc_sb.push_back(3'(v));
        mask_sb.push_back(emask);
    endtask

    // Starts a run on dut0 and scores it; pulse_at injects START on that busy cycle.
    task automatic run0(input string name, input int m, input logic [7:0] emask,
                        input int pulse_at);
        int         cyc;
        logic [2:0] exp_abc;
        logic [7:0] exp_mask;
        mode = m;
        push_expected(3, emask);
        @(negedge ck); start0 = 1'b1;
        @(negedge ck); start0 = 1'b0;
        checks++;
        if (mask0 !== 8'h00 || cnt0 !== 4'd0 || busy0 !== 1'b1 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL %s start_clear: mask=%h cnt=%0d busy=%b done=%b, want 00/0/1/0",
                     name, mask0, cnt0, busy0, done0);
        end
        cyc = 0;
        while (!done0 && cyc < 200) begin
            checks++;
            exp_abc = (abc_sb.size() > 0) ? abc_sb.pop_front() : 3'bxxx;
            if ({a0, b0, ci0} !== exp_abc || cnt0 !== 4'($countones(mask0))) begin
                errors++;
                $display("FAIL %s vector cyc%0d: abc=%b cnt=%0d mask=%h, want abc=%b cnt=popcount",
                         name, cyc, {a0, b0, ci0}, cnt0, mask0, exp_abc);
            end
            cyc++;
            start0 = (cyc == pulse_at);
            @(negedge ck);
        end
        start0 = 1'b0;
        exp_mask = mask_sb.pop_front();
        checks++;
        if (cyc != 24 || abc_sb.size() != 0) begin
            errors++;
            $display("FAIL %s latency: busy cycles=%0d left=%0d, want 24/0", name, cyc, abc_sb.size());
            abc_sb.delete();
        end
        checks++;
        if (mask0 !== exp_mask || cnt0 !== 4'($countones(exp_mask)) || pass0 !== (exp_mask == 8'h00)
            || busy0 !== 1'b0 || {a0, b0, ci0} !== 3'b000) begin
            errors++;
            $display("FAIL %s result: mask=%h cnt=%0d pass=%b busy=%b abc=%b, want mask=%h",
                     name, mask0, cnt0, pass0, busy0, {a0, b0, ci0}, exp_mask);
        end
        repeat (3) @(negedge ck);
        checks++;
        if (done0 !== 1'b1 || mask0 !== exp_mask) begin
            errors++;
            $display("FAIL %s done_hold: done=%b mask=%h, want 1/%h", name, done0, mask0, exp_mask);
        end
    endtask

    task automatic test_reset();
        rn = 1'b0; start0 = 1'b0; start1 = 1'b0; mode = 0;
        #12;
        checks++;
        if ({a0, b0, ci0, busy0, done0, pass0, mask0, cnt0} !== 18'd0 ||
            {a1, b1, ci1, busy1, done1, pass1, mask1, cnt1} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: dut0=%h dut1=%h, want 0",
                     {a0, b0, ci0, busy0, done0, pass0, mask0, cnt0},
                     {a1, b1, ci1, busy1, done1, pass1, mask1, cnt1});
        end
        @(negedge ck); rn = 1'b1;
        repeat (2) @(negedge ck);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_wait: busy=%b done=%b, want 0/0", busy0, done0);
        end
    endtask

    task automatic test_settle1();
        int         cyc;
        logic [2:0] exp_abc;
        push_expected(2, 8'h00);
        @(negedge ck); start1 = 1'b1;
        @(negedge ck); start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 200) begin
            checks++;
            exp_abc = (abc_sb.size() > 0) ? abc_sb.pop_front() : 3'bxxx;
            if ({a1, b1, ci1} !== exp_abc) begin
                errors++;
                $display("FAIL settle1 vector cyc%0d: abc=%b, want %b", cyc, {a1, b1, ci1}, exp_abc);
            end
            cyc++;
            @(negedge ck);
        end
        void'(mask_sb.pop_front());
        checks++;
        if (cyc != 16 || pass1 !== 1'b1 || mask1 !== 8'h00 || cnt1 !== 4'd0) begin
            errors++;
            $display("FAIL settle1 result: cycles=%0d pass=%b mask=%h cnt=%0d, want 16/1/00/0",
                     cyc, pass1, mask1, cnt1);
        end
        abc_sb.delete();
    endtask

    task automatic test_mid_reset();
        int cyc;
        mode = 0;
        @(negedge ck); start0 = 1'b1;
        @(negedge ck); start0 = 1'b0;
        cyc = 0;
        while ({a0, b0, ci0} !== 3'd3 && cyc < 100) begin
            cyc++;
            @(negedge ck);
        end
        #2 rn = 1'b0;
        #1;
        checks++;
        if (cyc >= 100 || {a0, b0, ci0, busy0, done0, pass0, mask0, cnt0} !== 18'd0) begin
            errors++;
            $display("FAIL mid_reset: waited=%0d outs=%h, want outputs 0",
                     cyc, {a0, b0, ci0, busy0, done0, pass0, mask0, cnt0});
        end
        @(negedge ck); rn = 1'b1;
        repeat (3) @(negedge ck);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: busy=%b done=%b, want 0/0", busy0, done0);
        end
        run0("after_reset", 0, 8'h00, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        run0("ideal", 0, 8'h00, 0);
        run0("s_stuck0", 1, 8'h96, 0);
        run0("restart_from_fail", 0, 8'h00, 0);
        run0("co_inverted", 2, 8'hFF, 24);
        run0("busy_start", 0, 8'h00, 5);
        test_settle1();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fa_cell_bist

`default_nettype wire

// File: doc/fa_cell_bist.md
# fa_cell_bist

Built-in self-test sequencer for a single full-adder cell (FA_X1 or equivalent). It drives all eight A/B/CI input combinations into the cell under test and waits a programmable settle time per vector. It then samples CO/S, compares them against the arithmetic golden values and reports a per-vector fail mask and a summary pass flag. It sits beside each characterised adder cell in the cell-validation harness and replaces the open-loop display-only stimulus with a closed-loop checker.

## Interface
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15
- CK  in  1  clock, rising edge
- RN  in  1  asynchronous reset, active-low
- START  in  1  begin a test run; sampled only in IDLE or DONE
- A  out  1  drive to cell input A
- B  out  1  drive to cell input B
- CI  out  1  drive to cell carry-in
- CO_IN  in  1  cell carry-out under test
- S_IN  in  1  cell sum under test
- BUSY  out  1  run in progress
- DONE  out  1  run complete, results valid; held until next START
- PASS  out  1  DONE and no vector failed
- FAIL_MASK  out  8  bit i set if vector i mismatched
- FAIL_CNT  out  4  number of failing vectors, 0..8

## Operation
- Vector index v is 3 bits, with {A,B,CI} = v: v=0 is 000 and v=7 is 111, applied in ascending order.
- Golden values: exp_S = A^B^CI and exp_CO = majority(A,B,CI). A vector fails if CO_IN != exp_CO or S_IN != exp_S.
- FSM states:
  - IDLE: A=B=CI=0, BUSY=0, DONE=0. START=1 moves to DRIVE with v=0, settle counter 0, and FAIL_MASK/FAIL_CNT cleared.
  - DRIVE: A/B/CI are registered from v. The state lasts SETTLE_CYCLES cycles, then moves to CHECK.
  - CHECK: one cycle with A/B/CI still held. On the exiting edge, CO_IN/S_IN are compared and FAIL_MASK[v] and FAIL_CNT are updated. If v==7 the FSM moves to DONE; otherwise v increments and the FSM returns to DRIVE.
  - DONE: DONE=1, BUSY=0, PASS=(FAIL_CNT==0), A=B=CI=0. START=1 restarts exactly as from IDLE and clears the results on the same edge.
- BUSY=1 in DRIVE and CHECK. START in those states is ignored.
- CO_IN/S_IN are sampled only on CHECK edges. Values in other states have no effect.
- FAIL_CNT is a saturating-free 4-bit count, maximum 8. FAIL_CNT always equals popcount(FAIL_MASK).
- Outputs A/B/CI come straight from flops, with no combinational path from START.

## Timing
- Reset (RN=0, asynchronous, immediate): state IDLE; A=B=CI=0; BUSY=0; DONE=0; PASS=0; FAIL_MASK=0; FAIL_CNT=0; v=0.
- Reset mid-run: the run aborts with no partial results retained. After RN releases, the block waits in IDLE for START.
- Per-vector period is SETTLE_CYCLES+1 cycles. The first vector is on A/B/CI in the cycle after the START edge.
- Let N be the START sampling edge. DONE rises after edge N+8*(SETTLE_CYCLES+1), which is 24 cycles for the default.
- FAIL_MASK/FAIL_CNT update during the run. They are final only when DONE=1.
- START asserted on the same edge as the DONE entry has no effect, because the state is still CHECK. START must be held or reasserted once DONE=1.

## Structure
- Shared package fa_bist_pkg holds:
  - the state enum {IDLE, DRIVE, CHECK, DONE};
  - NUM_VECTORS=8;
  - the function fa_golden(v) returning {exp_CO, exp_S}.
- A single module: FSM, settle counter (4-bit), vector counter, and result registers. No sub-module is needed.
- The harness top instantiates fa_cell_bist beside the cell under test.

## Test plan
- Ideal behavioural adder, default SETTLE_CYCLES -> DONE 24 cycles after START, PASS=1, FAIL_MASK=8'h00, FAIL_CNT=0, A/B/CI step 000..111.
- S_IN stuck-at-0 -> FAIL_MASK=8'h96 (v=1,2,4,7), FAIL_CNT=4, PASS=0.
- CO_IN inverted -> FAIL_MASK=8'hFF, FAIL_CNT=8, PASS=0.
- SETTLE_CYCLES=1 with the ideal adder -> DONE after 16 cycles. Each vector is held 2 cycles, and CHECK occurs in the 2nd.
- RN pulsed low during v=3 -> all outputs reset immediately. A following START with the ideal adder completes with PASS=1 and FAIL_MASK=0.
- START pulsed while BUSY -> no restart, and DONE timing is unchanged. START in DONE after a failing run -> FAIL_MASK clears on that edge and the new run with the ideal adder ends with PASS=1.
